edge_debouncer: RTL and testbench

EDGE_DEBOUNCER -- requirements
Module: edge_debouncer

---
 rtl/edge_debouncer.sv | 183 ++++++++++++++++++
 tb/tb_edge_debouncer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/edge_debouncer.sv
// ---------------------------------------------------------------------------
// edge_debouncer
//
// Debounces a raw, asynchronous level such as a button or switch. The input
// first passes through a two-flop synchronizer. A four-state FSM then accepts
// a new level only after it has been seen on DEBOUNCE_CYCLES consecutive
// clock edges. When a level is accepted, the block updates the registered
// level and emits a one-cycle rise or fall pulse.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive samples a new level must persist (2..2**CNT_W)
//   CNT_W           : width of the qualification counter
//
// Ports
//   clk  : clock; all state updates on the rising edge
//   rst  : asynchronous, active-high reset
//   din  : raw asynchronous input level
//   q    : debounced, clk-synchronous level (registered)
//   rise : one-cycle pulse when q goes 0->1 (registered)
//   fall : one-cycle pulse when q goes 1->0 (registered)
//   busy : high while a candidate level change is being qualified
//
// Latency: suppose din changes and holds, and edge k is the first edge to
// capture the new value into s1. Then q and the pulse update at edge
// k+DEBOUNCE_CYCLES+1.
// ---------------------------------------------------------------------------
module edge_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    // The counter value on the cycle that accepts the candidate level.
    // It counts from 1 on WAIT_* entry, so the accepting edge is the
    // DEBOUNCE_CYCLES-th consecutive sample of the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dout_q,  dout_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    // Two-flop synchronizer. Only s2_q is allowed to reach the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // By default the block holds the level, holds the count and emits no
    // pulse. Pulses are recomputed every cycle, so each one lasts exactly
    // one cycle. Any sample of the opposite level during WAIT_* drops back
    // to the stable state and clears the count. A later attempt therefore
    // restarts from 1 with no partial credit.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            STABLE_LO: begin
                if (s2_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end

            WAIT_HI: begin
                if (!s2_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            STABLE_HI: begin
                if (!s2_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end

            WAIT_LO: begin
                if (s2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // busy is decoded only from the state register. This keeps it glitch-free
    // and aligned with q, rise and fall.
    // -----------------------------------------------------------------------
    assign q    = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);

    // -----------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------
    a_no_dual_pulse: assert property (@(posedge clk) disable iff (rst)
        !(rise_q && fall_q));

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= CNT_LAST);

    // The level always agrees with the stable state it was accepted into.
    a_level_state: assert property (@(posedge clk) disable iff (rst)
        (state_q == STABLE_HI) -> dout_q);

endmodule

// File: tb/tb_edge_debouncer.sv
// ---------------------------------------------------------------------------
// tb_edge_debouncer
//
// Self-checking bench for edge_debouncer at its default parameters.
// The main stimulus comes from a table of per-cycle records. Each record
// holds the rst and din values plus the expected {q, rise, fall, busy}.
// Inputs are driven on the falling edge, and each record's expectation is
// pushed into a queue. After the following rising edge the record is popped
// and compared. Hand-written sequences cover the asynchronous reset cases.
// ---------------------------------------------------------------------------
module tb_edge_debouncer;

    logic clk;
    logic rst;
    logic din;
    logic q, rise, fall, busy;

    edge_debouncer #(
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    // 50 ns clock period
    initial clk = 1'b0;
    always #25 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       din;
        logic [3:0] exp;   // {q, rise, fall, busy}
        string      tag;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic logic [3:0] pk(input logic eq, input logic er,
                                      input logic ef, input logic eb);
        return {eq, er, ef, eb};
    endfunction

    task automatic add(input logic r, input logic d, input logic [3:0] e,
                       input string t);
        vec_t v;
        v.rst = r; v.din = d; v.exp = e; v.tag = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string t, input logic [3:0] got,
                         input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d q/rise/fall/busy got=%b expected=%b",
                     t, cyc, got, want);
        end
    endtask

    // Drive one cycle and queue its expectation. After the rising edge, pop
    // the oldest queued expectation and compare it against the DUT.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst;
        din = v.din;
        sb.push_back(v);
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty cyc=%0d got=none expected=entry", cyc);
        end else begin
            e = sb.pop_front();
            check(e.tag, {q, rise, fall, busy}, e.exp);
        end
    endtask

    task automatic step_rd(input logic r, input logic d, input logic [3:0] e,
                           input string t);
        vec_t v;
        v.rst = r; v.din = d; v.exp = e; v.tag = t;
        step(v);
    endtask

    // Watchdog
    initial begin
        #100us;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic td;
        rst = 1'b1;
        din = 1'b0;

        // Async reset holds the outputs low before any clock edge.
        #1;
        check("reset_async_t0", {q, rise, fall, busy}, 4'b0000);

        // ---------------- build vector table ----------------
        // Reset for 2 cycles, then idle low.
        for (int j = 0; j < 2; j++) add(1'b1, 1'b0, 4'b0000, "reset_hold");
        for (int j = 0; j < 4; j++) add(1'b0, 1'b0, 4'b0000, "idle_lo");

        // Glitch: din high for 3 cycles. The FSM sees the high sample at
        // edges 2, 3 and 4, then sees low at edge 5 and aborts.
        for (int j = 0; j < 11; j++)
            add(1'b0, (j < 3), pk(1'b0, 1'b0, 1'b0, (j >= 2 && j <= 4)), "glitch");

        // Rise: din held high 20 cycles. Edge k=0 loads s1, busy covers
        // k+2..k+8, and q/rise change at k+9.
        for (int j = 0; j < 20; j++)
            add(1'b0, 1'b1, pk((j >= 9), (j == 9), 1'b0, (j >= 2 && j <= 8)), "rise");

        // Fall: din held low 20 cycles starting from q=1.
        for (int j = 0; j < 20; j++)
            add(1'b0, 1'b0, pk((j < 9), 1'b0, (j == 9), (j >= 2 && j <= 8)), "fall");

        // Toggle every cycle for 50 cycles, starting from q=0. The FSM sees
        // din from two edges earlier, so busy is high exactly on even edges
        // >= 2. After the toggling stops, the last high sample (j=48) is seen
        // at edge 50.
        for (int j = 0; j < 56; j++) begin
            td = (j < 50) && (j % 2 == 0);
            add(1'b0, td, pk(1'b0, 1'b0, 1'b0, (j >= 2) && (j <= 50) && (j % 2 == 0)),
                "toggle");
        end

        // ---------------- apply table ----------------
        foreach (vecs[i]) step(vecs[i]);

        // ---------------- reset mid WAIT_HI ----------------
        // din goes high at edge 0. cnt=1 at edge 2 and cnt=5 at edge 6.
        for (int j = 0; j < 7; j++)
            step_rd(1'b0, 1'b1, pk(1'b0, 1'b0, 1'b0, (j >= 2)), "pre_rst_wait");

        // Assert rst between edges. The outputs must clear with no clock.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_async", {q, rise, fall, busy}, 4'b0000);
        @(posedge clk);
        #1;
        cyc++;
        check("rst_mid_edge", {q, rise, fall, busy}, 4'b0000);

        // Release with din still high. The first post-release edge is k, and
        // rise must appear at k+9, not earlier.
        for (int j = 0; j < 14; j++)
            step_rd(1'b0, 1'b1, pk((j >= 9), (j == 9), 1'b0, (j >= 2 && j <= 8)),
                    "post_rst_rise");

        // ---------------- reset while q=1 ----------------
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_q_hi_async", {q, rise, fall, busy}, 4'b0000);
        for (int j = 0; j < 2; j++)
            step_rd(1'b1, 1'b0, 4'b0000, "rst_q_hi_hold");
        for (int j = 0; j < 12; j++)
            step_rd(1'b0, 1'b0, 4'b0000, "post_rst_idle");

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
